// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with NCO timing, majority vote and holding register
// Frames are sampled 3x around mid-bit; completed words land in a ready/valid holding register.
module uart_rx_cfg #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned ACC_WIDTH  = 24,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 parity_err,
   output logic                 framing_err,
   output logic                 break_det,
   output logic                 overrun,
   output logic                 busy
);

   localparam logic [63:0] INCR64 =
      (((64'(BAUD) * 64'(OVERSAMPLE)) << ACC_WIDTH) + 64'(CLK_HZ / 2)) / 64'(CLK_HZ);
   localparam logic [ACC_WIDTH:0] INCR = INCR64[ACC_WIDTH:0];
   localparam int unsigned CW  = $clog2(OVERSAMPLE);
   localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int unsigned MID = OVERSAMPLE / 2;
   localparam logic PAR_ODD = (PARITY == 2);

   generate
      if (INCR64 == 64'd0 || INCR64 > (64'd1 << ACC_WIDTH)) begin : g_bad_incr
         $error("uart_rx_cfg: NCO increment out of range");
      end
      if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 ||
          DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
         $error("uart_rx_cfg: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   phase_q;
   logic [ACC_WIDTH:0]     phase_sum;
   logic                   os_tick_q;
   logic                   rx_meta_q, rx_sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_idx_q, bit_idx_d;
   logic                   stop_idx_q, stop_idx_d;
   logic [1:0]             samp_q, samp_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_acc_q, par_acc_d, perr_q, perr_d, par_vote_q, par_vote_d;
   logic                   ferr_q, ferr_d, stop0_q, stop0_d;
   logic                   vote, at_dec, at_end, complete, brk, fe_fin, first_stop;
   logic [DATA_BITS-1:0]   m_data_q;
   logic                   m_valid_q, pe_q, fe_q, bk_q, overrun_q;

   assign phase_sum = {1'b0, phase_q} + INCR;
   assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);
   assign at_dec = os_tick_q && (cnt_q == CW'(MID + 1));
   assign at_end = os_tick_q && (cnt_q == CW'(OVERSAMPLE - 1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      par_acc_d  = par_acc_q;
      perr_d     = perr_q;
      par_vote_d = par_vote_q;
      ferr_d     = ferr_q;
      stop0_d    = stop0_q;
      complete   = 1'b0;
      brk        = 1'b0;
      fe_fin     = ferr_q;
      first_stop = stop0_q;

      if (os_tick_q && state_q != S_IDLE && state_q != S_BREAK_WAIT) begin
         cnt_d = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);
         if (cnt_q == CW'(MID - 1)) samp_d[0] = rx_sync_q;
         if (cnt_q == CW'(MID)) samp_d[1] = rx_sync_q;
      end

      case (state_q)
         S_IDLE: begin
            if (os_tick_q && !rx_sync_q) begin
               state_d    = S_START;
               cnt_d      = '0;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               shift_d    = '0;
               par_acc_d  = 1'b0;
               perr_d     = 1'b0;
               par_vote_d = 1'b0;
               ferr_d     = 1'b0;
               stop0_d    = 1'b0;
            end
         end
         S_START: begin
            if (at_dec && vote) state_d = S_IDLE;
            else if (at_end) state_d = S_DATA;
         end
         S_DATA: begin
            if (at_dec) begin
               shift_d   = {vote, shift_q[DATA_BITS-1:1]};
               par_acc_d = par_acc_q ^ vote;
            end
            if (at_end) begin
               if (bit_idx_q == BW'(DATA_BITS - 1)) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               else bit_idx_d = bit_idx_q + BW'(1);
            end
         end
         S_PARITY: begin
            if (at_dec) begin
               par_vote_d = vote;
               perr_d     = ((par_acc_q ^ vote) != PAR_ODD);
            end
            if (at_end) state_d = S_STOP;
         end
         S_STOP: begin
            if (at_dec) begin
               if (!vote) ferr_d = 1'b1;
               if (!stop_idx_q) stop0_d = vote;
               if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                  // Completion at mid-stop so a start edge in the tail half-bit is caught.
                  complete   = 1'b1;
                  fe_fin     = ferr_q | !vote;
                  first_stop = stop_idx_q ? stop0_q : vote;
                  brk        = (shift_q == '0) && (PARITY == 0 || !par_vote_q) && !first_stop;
                  state_d    = brk ? S_BREAK_WAIT : S_IDLE;
               end
            end
            if (at_end && !complete) stop_idx_d = 1'b1;
         end
         S_BREAK_WAIT: begin
            if (os_tick_q && rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= '0;
         os_tick_q  <= 1'b0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         samp_q     <= '0;
         shift_q    <= '0;
         par_acc_q  <= 1'b0;
         perr_q     <= 1'b0;
         par_vote_q <= 1'b0;
         ferr_q     <= 1'b0;
         stop0_q    <= 1'b0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         bk_q       <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         phase_q    <= phase_sum[ACC_WIDTH-1:0];
         os_tick_q  <= phase_sum[ACC_WIDTH];
         rx_meta_q  <= rx_i;
         rx_sync_q  <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         par_acc_q  <= par_acc_d;
         perr_q     <= perr_d;
         par_vote_q <= par_vote_d;
         ferr_q     <= ferr_d;
         stop0_q    <= stop0_d;
         overrun_q  <= 1'b0;
         if (complete) begin
            if (!m_valid_q || m_ready) begin
               m_data_q  <= brk ? '0 : shift_q;
               pe_q      <= perr_q;
               fe_q      <= fe_fin | brk;
               bk_q      <= brk;
               m_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (m_valid_q && m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end

   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign parity_err  = pe_q;
   assign framing_err = fe_q;
   assign break_det   = bk_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed scoreboard bench for uart_rx_cfg (8N1, 7E1, 8N2 instances)
// One bit = 16 clk; a negedge monitor pops expected words on each handshake.
module tb_uart_rx_cfg;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx = 1'b1;
   logic m_ready = 1'b1;
   int   sel = 0;

   always #5 clk = ~clk;

   logic rx0, rx1, rx2;
   assign rx0 = (sel == 0) ? rx : 1'b1;
   assign rx1 = (sel == 1) ? rx : 1'b1;
   assign rx2 = (sel == 2) ? rx : 1'b1;

   logic [7:0] m_data0, m_data2;
   logic [6:0] m_data1;
   logic mv0, mv1, mv2, pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, ov0, ov1, ov2, by0, by1, by2;

   uart_rx_cfg #(.CLK_HZ(1_843_200), .BAUD(115_200), .OVERSAMPLE(16)) u_8n1 (
      .clk(clk), .rst(rst), .rx_i(rx0), .m_data(m_data0), .m_valid(mv0), .m_ready(m_ready),
      .parity_err(pe0), .framing_err(fe0), .break_det(bk0), .overrun(ov0), .busy(by0));

   uart_rx_cfg #(.CLK_HZ(1_843_200), .BAUD(115_200), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1)) u_7e1 (
      .clk(clk), .rst(rst), .rx_i(rx1), .m_data(m_data1), .m_valid(mv1), .m_ready(m_ready),
      .parity_err(pe1), .framing_err(fe1), .break_det(bk1), .overrun(ov1), .busy(by1));

   uart_rx_cfg #(.CLK_HZ(1_843_200), .BAUD(115_200), .OVERSAMPLE(16), .STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst(rst), .rx_i(rx2), .m_data(m_data2), .m_valid(mv2), .m_ready(m_ready),
      .parity_err(pe2), .framing_err(fe2), .break_det(bk2), .overrun(ov2), .busy(by2));

   logic [8:0] md [3];
   logic [2:0] flg [3];
   logic       mv [3];
   logic       ov [3];
   assign md[0] = {1'b0, m_data0};
   assign md[1] = {2'b0, m_data1};
   assign md[2] = {1'b0, m_data2};
   assign flg[0] = {pe0, fe0, bk0};
   assign flg[1] = {pe1, fe1, bk1};
   assign flg[2] = {pe2, fe2, bk2};
   assign mv[0] = mv0;
   assign mv[1] = mv1;
   assign mv[2] = mv2;
   assign ov[0] = ov0;
   assign ov[1] = ov1;
   assign ov[2] = ov2;

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic [2:0] flg;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t_start = 0;
   int rise_cyc [3] = '{0, 0, 0};
   int vcnt [3] = '{0, 0, 0};
   int ocnt [3] = '{0, 0, 0};
   logic mv_prev [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_word(input int i, input logic [8:0] d, input logic [2:0] f);
      exp_t e;
      e.inst = i;
      e.data = d;
      e.flg  = f;
      sb.push_back(e);
   endtask

   task automatic check_word(input int i);
      exp_t e;
      chk("word_expected", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("word_inst_data", {4'(i), 3'b0, md[i]}, {4'(e.inst), 3'b0, e.data});
         chk("word_flags_pe_fe_bk", {13'b0, flg[i]}, {13'b0, e.flg});
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            if (ov[i]) ocnt[i]++;
            if (mv[i]) vcnt[i]++;
            if (mv[i] && !mv_prev[i]) rise_cyc[i] = cyc;
            if (mv[i] && m_ready) check_word(i);
         end
         mv_prev[i] = mv[i];
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int s, input logic [8:0] d, input int nb, input int pmode,
                       input logic pflip, input logic [1:0] stops, input int ns);
      logic p;
      sel = s;
      t_start = cyc;
      rx = 1'b0;
      tick(16);
      p = 1'b0;
      for (int k = 0; k < nb; k++) begin
         rx = d[k];
         p ^= d[k];
         tick(16);
      end
      if (pmode != 0) begin
         if (pmode == 2) p = ~p;
         rx = p ^ pflip;
         tick(16);
      end
      for (int j = 0; j < ns; j++) begin
         rx = stops[j];
         tick(16);
      end
      rx = 1'b1;
      tick(16);
   endtask

   initial begin
      int base_v, base_o;
      logic [7:0] v;

      tick(4);
      chk("reset_8n1_outputs", {m_data0, mv0, pe0, fe0, bk0, ov0, by0, 2'b0}, 16'h0);
      chk("reset_7e1_outputs", {1'b0, m_data1, mv1, pe1, fe1, bk1, ov1, by1, 2'b0}, 16'h0);
      chk("reset_8n2_outputs", {m_data2, mv2, pe2, fe2, bk2, ov2, by2, 2'b0}, 16'h0);
      rst = 1'b0;
      tick(8);

      // 8N1 0xA5: 1 edge to sample rx_i + 2 sync flops + 9*16+9+1 = 157
      base_v = vcnt[0];
      expect_word(0, 9'hA5, 3'b000);
      send(0, 9'hA5, 8, 0, 1'b0, 2'b11, 1);
      chk("a5_valid_latency", 16'(rise_cyc[0] - t_start), 16'd157);
      chk("a5_valid_one_clk", 16'(vcnt[0] - base_v), 16'd1);

      expect_word(1, 9'h35, 3'b000);
      send(1, 9'h35, 7, 1, 1'b0, 2'b11, 1);
      expect_word(1, 9'h35, 3'b100);
      send(1, 9'h35, 7, 1, 1'b1, 2'b11, 1);

      expect_word(2, 9'h3C, 3'b010);
      send(2, 9'h3C, 8, 0, 1'b0, 2'b01, 2);
      expect_word(2, 9'h3C, 3'b000);
      send(2, 9'h3C, 8, 0, 1'b0, 2'b11, 2);

      base_v = vcnt[0];
      sel = 0;
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(16);
      chk("glitch_busy_idle", 16'(by0), 16'd0);
      chk("glitch_no_word", 16'(vcnt[0] - base_v), 16'd0);

      // 0x00 with a 1-clk high pulse hitting the MID sample of data bit 3
      expect_word(0, 9'h000, 3'b000);
      sel = 0;
      rx = 1'b0;
      tick(16 + 48 + 9);
      rx = 1'b1;
      tick(1);
      rx = 1'b0;
      tick(6 + 64);
      rx = 1'b1;
      tick(32);

      expect_word(0, 9'h000, 3'b011);
      rx = 1'b0;
      tick(30 * 16);
      chk("break_wait_busy", 16'(by0), 16'd1);
      rx = 1'b1;
      tick(32);
      chk("break_left_busy", 16'(by0), 16'd0);
      expect_word(0, 9'h05A, 3'b000);
      send(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1);

      base_o = ocnt[0];
      m_ready = 1'b0;
      expect_word(0, 9'h011, 3'b000);
      send(0, 9'h011, 8, 0, 1'b0, 2'b11, 1);
      send(0, 9'h022, 8, 0, 1'b0, 2'b11, 1);
      tick(16);
      chk("overrun_pulse_count", 16'(ocnt[0] - base_o), 16'd1);
      chk("overrun_held_valid", 16'(mv0), 16'd1);
      chk("overrun_held_data", {8'b0, m_data0}, 16'h0011);
      m_ready = 1'b1;
      tick(2);
      chk("overrun_accept_clears", 16'(mv0), 16'd0);

      v = 8'h5A;
      sel = 0;
      rx = 1'b0;
      tick(16);
      for (int k = 0; k < 4; k++) begin
         rx = v[k];
         tick(16);
      end
      rx = v[4];
      tick(8);
      chk("midframe_busy", 16'(by0), 16'd1);
      rst = 1'b1;
      tick(1);
      chk("midreset_outputs", {m_data0, mv0, pe0, fe0, bk0, ov0, by0, 2'b0}, 16'h0);
      rx = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(32);
      expect_word(0, 9'h0C3, 3'b000);
      send(0, 9'h0C3, 8, 0, 1'b0, 2'b11, 1);

      tick(64);
      chk("scoreboard_drained", 16'(sb.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor UART receiver for the host link. It supports configurable data width, optional parity, one or two stop bits, and 3-sample majority voting at mid-bit. It also detects break conditions and drives a ready/valid output holding register with overrun reporting. It sits between the synchronised serial pin and the command/byte-stream parser.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bits/s
OVERSAMPLE, 16, oversample ticks per bit; legal range 8..32, even
ACC_WIDTH, 24, NCO phase accumulator width
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits checked: 1 or 2

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
rx_i  in  1  asynchronous serial input; idle high
m_data  out  DATA_BITS  received word, LSB = first bit on the line
m_valid  out  1  holding register full; held until accepted
m_ready  in  1  consumer accepts when m_valid && m_ready
parity_err  out  1  parity mismatch on the held word; qualified by m_valid
framing_err  out  1  a stop bit sampled low on the held word; qualified by m_valid
break_det  out  1  held word is a break; qualified by m_valid
overrun  out  1  one-cycle pulse when a completed frame is dropped
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Synchroniser: 2-flop synchroniser on rx_i, reset value 1. All logic uses rx_sync.
- NCO:
  - INCR = round(BAUD*OVERSAMPLE*2^ACC_WIDTH / CLK_HZ), computed at elaboration in 64-bit arithmetic.
  - Elaboration error if INCR == 0 or INCR > 2^ACC_WIDTH.
  - Each clock: phase += INCR. os_tick is registered and equals the carry out of bit ACC_WIDTH; the carry is dropped from phase.
  - Reset: phase = 0, os_tick = 0.
- Sampling:
  - MID = OVERSAMPLE/2.
  - Per bit, sample_cnt counts 0..OVERSAMPLE-1 on os_tick.
  - Bit value = majority of rx_sync at counts MID-1, MID, MID+1.
  - Bit decision is made at count MID+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. All transitions occur only on os_tick unless noted.
  - IDLE: on rx_sync == 0, go to START with sample_cnt = 0.
  - START:
    - At the decision point, a vote of 1 is a false start: return to IDLE with no flags.
    - A vote of 0 continues. At count OVERSAMPLE-1 go to DATA with bit_idx = 0.
  - DATA:
    - Shift each vote in LSB-first, and XOR-accumulate parity.
    - After bit DATA_BITS-1 completes: go to PARITY if PARITY != 0, else STOP.
  - PARITY:
    - Even mode: error if (accumulated parity XOR vote) != 0.
    - Odd mode: error if it != 1.
  - STOP: check each of the STOP_BITS stop bits; a vote of 0 sets the frame's framing error. Completion is at the decision point of the last stop bit.
- Frame completion:
  - On completion, the FSM returns to IDLE immediately, so a start edge during the remaining half stop bit is detected.
  - Break: data all 0, parity vote 0 (if present) and first stop vote 0. Then break_det = 1, framing_err = 1, m_data = 0, and the FSM goes to BREAK_WAIT instead of IDLE.
  - BREAK_WAIT: leave for IDLE on the first os_tick with rx_sync == 1.
- Output holding register:
  - At completion, if !m_valid or (m_valid && m_ready) in the same cycle: load m_data and the three error flags, and set m_valid = 1 on the next clock.
  - Latency: m_valid rises 1 clk after the completing os_tick.
  - Otherwise the new frame is dropped, the old word is retained, and overrun pulses high for 1 clk.
  - m_valid && m_ready with no completion clears m_valid.
  - Error flags and m_data are stable while m_valid = 1.
- Reset:
  - All outputs are 0 (m_data = 0, m_valid = 0, flags = 0, busy = 0).
  - State = IDLE; counters and shift register = 0.
  - Mid-frame reset discards the partial frame. After reset, a frame needs a fresh falling edge.

Test Plan:
Common setup: CLK_HZ = 1_843_200, BAUD = 115_200, OVERSAMPLE = 16, so INCR = 2^24, os_tick is high every clk, and 1 bit = 16 clk.
1. Defaults (8N1): send 0xA5 with m_ready = 1 -> m_data = 0xA5, m_valid for 1 clk, all flags 0; m_valid rises 1 clk after the stop decision, 9*16+9+1 clk after the falling edge (after the 2-flop synchroniser delay).
2. PARITY = 1, DATA_BITS = 7: send 0x35 with correct even parity -> parity_err = 0. Send 0x35 with parity bit flipped -> m_data = 0x35, parity_err = 1.
3. STOP_BITS = 2: send 0x3C with the second stop bit low -> framing_err = 1. Send 0x3C with both stop bits high -> no error.
4. Glitches: 4-clk low glitch on idle line -> no m_valid, busy returns to 0 within 16 clk. Single-clk glitch at the mid-sample of data bit 3 of 0x00 -> m_data = 0x00 (majority vote rejects it).
5. Break and overrun:
   - Hold rx_i low for 30 bit times -> one word: m_data = 0, break_det = 1, framing_err = 1. No second frame until the line has been high for at least one os_tick.
   - With m_ready = 0, send 0x11 then 0x22 -> m_data stays 0x11, overrun pulses once. Raise m_ready -> 0x11 is accepted and m_valid falls.
6. Reset mid-frame: assert rst at data bit 4 of 0x5A -> all outputs 0 next clk. After release, send 0xC3 -> m_data = 0xC3 only; no corrupted word is emitted.
